layer2_fifo_wr_arbiter: RTL and testbench

Packet-atomic round-robin arbiter sharing the single write port of the layer-2 sync FIFO (16-bit, depth 1024) among NUM_SRC spike-packet producers. A grant is held for a whole packet, which is terminated by the end-of-packet word 16'hFAF1. The arbiter registers the FIFO write and applies back-pressure from the FIFO's full/almost_full flags so the FIFO never overflows. It sits between the layer-1 neuron-core output streams and the layer-2 FIFO write side.

---
 rtl/l2arb_pkg.sv | 17 +
 rtl/layer2_fifo_wr_arbiter_l2_rr_picker.sv | 26 ++
 rtl/layer2_fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_layer2_fifo_wr_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2arb_pkg.sv
// Shared definitions for the layer-2 FIFO write arbiter and its round-robin picker.
package l2arb_pkg;

  localparam logic [15:0] EOP_WORD = 16'hFAF1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TERM = 2'd2
  } state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer2_fifo_wr_arbiter_l2_rr_picker.sv
// l2_rr_picker: combinational rotate-priority encoder, first requester after 'last' wins.
module l2_rr_picker
  import l2arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  // Walk from furthest to nearest so the nearest requester after 'last' overwrites.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_SRC]) begin
        idx = SRC_W'((int'(last) + k) % NUM_SRC);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer2_fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the layer-2 FIFO write port.
// Optional packet length guard: define L2ARB_LEN_GUARD_EN.
module layer2_fifo_wr_arbiter
  import l2arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int WIDTH       = 16,
  parameter int MAX_PKT_LEN = 64,
  localparam int SRC_W      = src_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  input  logic                     fifo_full,
  input  logic                     fifo_almost_full,
  output logic [SRC_W-1:0]         grant_id,
  output logic                     busy,
  output logic [15:0]              pkt_count,
  output logic                     err_len
);

  state_t           state, state_nxt;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] pick;
  logic             pick_any;
  logic             space;
  logic             xfer;
  logic             inject;
  logic             is_eop;
  logic [WIDTH-1:0] gnt_word;

  l2_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_picker (
    .req  (src_valid),
    .last (last_grant),
    .idx  (pick),
    .any  (pick_any)
  );

`ifdef L2ARB_LEN_GUARD_EN
  localparam logic [7:0] LEN_LAST = 8'(MAX_PKT_LEN - 2);
  logic [7:0] len_cnt;
  logic       err_q;
  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

  // Accept only with two free slots so the single registered word can always land.
  assign space    = !fifo_full && !fifo_almost_full;
  assign gnt_word = src_data[int'(grant_id)*WIDTH +: WIDTH];
  assign is_eop   = (gnt_word == WIDTH'(EOP_WORD));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    src_ready = '0;
    xfer      = 1'b0;
    inject    = 1'b0;
    case (state)
      IDLE: if (pick_any) state_nxt = XFER;
      XFER: begin
        src_ready[grant_id] = space;
        xfer = space && src_valid[grant_id];
        if (xfer) begin
          if (is_eop) state_nxt = IDLE;
`ifdef L2ARB_LEN_GUARD_EN
          else if (len_cnt == LEN_LAST) state_nxt = TERM;
`endif
        end
      end
`ifdef L2ARB_LEN_GUARD_EN
      TERM: if (space) begin
        inject    = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output register stage: one word in flight toward the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_grant   <= SRC_W'(NUM_SRC - 1);
      grant_id     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      pkt_count    <= '0;
`ifdef L2ARB_LEN_GUARD_EN
      len_cnt      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      fifo_wr_en <= xfer || inject;
      if (state == IDLE && pick_any) begin
        grant_id   <= pick;
        last_grant <= pick;
      end
      if (xfer) fifo_wr_data <= gnt_word;
      else if (inject) fifo_wr_data <= WIDTH'(EOP_WORD);
      if ((xfer && is_eop) || inject) pkt_count <= pkt_count + 16'd1;
`ifdef L2ARB_LEN_GUARD_EN
      if (state == IDLE) len_cnt <= '0;
      else if (xfer) len_cnt <= len_cnt + 8'd1;
      if (inject) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_layer2_fifo_wr_arbiter.sv
// Bench for layer2_fifo_wr_arbiter: directed steps plus random traffic against a packet-level model.
module tb_layer2_fifo_wr_arbiter;
  import l2arb_pkg::*;

  localparam int N = 4;
  localparam int W = 16;
`ifdef L2ARB_LEN_GUARD_EN
  localparam int MPL    = 4;
  localparam int MAXLEN = 3;
`else
  localparam int MPL    = 64;
  localparam int MAXLEN = 8;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_full;
  logic           fifo_almost_full;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    pkt_count;
  logic           err_len;

  layer2_fifo_wr_arbiter #(.NUM_SRC(N), .WIDTH(W), .MAX_PKT_LEN(MPL)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .src_valid        (src_valid),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .busy             (busy),
    .pkt_count        (pkt_count),
    .err_len          (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producer-side word lists and the per-source order the FIFO must see them in.
  logic [15:0] stim_q [N][$];
  logic [15:0] exp_q  [N][$];
  bit          hold   [N];
  bit          af_drv, full_drv;
  int          cur_src;
  int          order_q[$];
  int          wr_total;
  int          exp_pkts;
  int          cyc;
  logic        wlog_en [0:63];
  logic [15:0] wlog_d  [0:63];
  bit          term_pending;
  int          cur_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mkword(input int s);
    return {1'b0, 3'(s), 12'($urandom)};
  endfunction

  task automatic add_pkt(input int s, input int len);
    logic [15:0] w;
    for (int k = 0; k < len - 1; k++) begin
      w = mkword(s);
      stim_q[s].push_back(w);
      exp_q[s].push_back(w);
    end
    stim_q[s].push_back(EOP_WORD);
    exp_q[s].push_back(EOP_WORD);
    exp_pkts++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
      hold[i] = 1'b0;
    end
    cur_src = -1;
    order_q.delete();
    exp_pkts = 0;
    term_pending = 1'b0;
    cur_len = 0;
    af_drv = 1'b0;
    full_drv = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (stim_q[i].size() > 0 && !hold[i]) begin
        src_valid[i] = 1'b1;
        src_data[i*W +: W] = stim_q[i][0];
      end else begin
        src_valid[i] = 1'b0;
        src_data[i*W +: W] = 16'($urandom);
      end
    end
    fifo_almost_full = af_drv;
    fifo_full = full_drv;
  endtask

  function automatic logic [31:0] head_or_bad(input int s);
    return (exp_q[s].size() > 0) ? {16'h0, exp_q[s][0]} : 32'hDEAD_BEEF;
  endfunction

  // One clock: drive at negedge, handshake before posedge, observe #1 after posedge.
  task automatic step();
    logic        nv;
    logic [15:0] nd, w;
    logic [N-1:0] acc;
    int s;
    drive();
    #1;
    chk("ready_onehot", 32'($countones(src_ready) <= 1), 32'd1);
    if (fifo_full || fifo_almost_full) chk("ready_backpressure", 32'(src_ready), 32'd0);
    acc = src_valid & src_ready;
    nv = 1'b0;
    nd = '0;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        nv = 1'b1;
        nd = stim_q[i][0];
      end
    if (term_pending && !fifo_full && !fifo_almost_full) begin
      nv = 1'b1;
      nd = EOP_WORD;
      term_pending = 1'b0;
      cur_len = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        if (stim_q[i][0] == EOP_WORD) cur_len = 0;
        else begin
          cur_len++;
`ifdef L2ARB_LEN_GUARD_EN
          if (cur_len == MPL - 1) term_pending = 1'b1;
`endif
        end
        void'(stim_q[i].pop_front());
      end
    if (cyc < 63) begin
      wlog_en[cyc+1] = fifo_wr_en;
      wlog_d[cyc+1]  = fifo_wr_data;
    end
    cyc++;
    chk("wr_en_latency", 32'(fifo_wr_en), 32'(nv));
    if (nv) chk("wr_data_latency", 32'(fifo_wr_data), 32'(nd));
    if (fifo_wr_en) begin
      wr_total++;
      w = fifo_wr_data;
      if (w == EOP_WORD) begin
        chk("eop_inside_packet", 32'(cur_src >= 0), 32'd1);
        if (cur_src >= 0) begin
          chk("eop_word", head_or_bad(cur_src), 32'(EOP_WORD));
          if (exp_q[cur_src].size() > 0) void'(exp_q[cur_src].pop_front());
        end
        cur_src = -1;
      end else begin
        s = int'(w[14:12]);
        if (cur_src < 0) begin
          cur_src = s;
          order_q.push_back(s);
        end
        chk("packet_atomic", 32'(s), 32'(cur_src));
        if (s < N) begin
          chk("word_order", head_or_bad(s), 32'(w));
          if (exp_q[s].size() > 0) void'(exp_q[s].pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < bound) begin
      step();
      n++;
      pending = (cur_src >= 0);
      for (int i = 0; i < N; i++)
        if (stim_q[i].size() > 0 || exp_q[i].size() > 0) pending = 1'b1;
    end
    chk("drain_complete", 32'(pending), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_model();
    drive();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic int order_at(input int k);
    return (k < order_q.size()) ? order_q[k] : -1;
  endfunction

  initial begin
    int c, base;
    rstn = 1'b0;
    src_valid = '0;
    src_data = '0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    wr_total = 0;
    cyc = 0;
    clear_model();
    #2;
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    do_reset();

    // Single source, 3-word packet: writes in cycles 2..4.
    stim_q[0] = '{16'h0011, 16'h0022, EOP_WORD};
    exp_q[0]  = '{16'h0011, 16'h0022, EOP_WORD};
    exp_pkts = 1;
    cyc = 0;
    for (int i = 0; i < 7; i++) step();
    chk("single_c1_en", 32'(wlog_en[1]), 32'd0);
    chk("single_c2_en", 32'(wlog_en[2]), 32'd1);
    chk("single_c2_d", 32'(wlog_d[2]), 32'h0011);
    chk("single_c3_d", 32'(wlog_d[3]), 32'h0022);
    chk("single_c4_d", 32'(wlog_d[4]), 32'hFAF1);
    chk("single_c4_en", 32'(wlog_en[4]), 32'd1);
    chk("single_c5_en", 32'(wlog_en[5]), 32'd0);
    chk("single_pkt_count", 32'(pkt_count), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Fairness from reset: grant order 0,1,2,3 repeating.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_pkt(s, 2);
    drain(200);
    chk("fair_pkts", 32'(order_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("fair_order", 32'(order_at(k)), 32'(k % N));
    chk("fair_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Back-pressure mid-packet.
    order_q.delete();
    base = wr_total;
    add_pkt(0, (MAXLEN < 6) ? MAXLEN : 6);
    step();
    step();
    af_drv = 1'b1;
    step();
    c = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fifo_wr_en) c++;
    end
    chk("bp_no_write", 32'(c), 32'd0);
    af_drv = 1'b0;
    drain(100);
    chk("bp_word_total", 32'(wr_total - base), 32'((MAXLEN < 6) ? MAXLEN : 6));

    // Valid gap on src1 while src2 waits.
    order_q.delete();
    add_pkt(1, MAXLEN);
    add_pkt(2, 3);
    step();
    step();
    step();
    hold[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gap_grant_held", 32'(grant_id), 32'd1);
      chk("gap_src2_wait", 32'(src_ready[2]), 32'd0);
    end
    hold[1] = 1'b0;
    drain(100);
    chk("gap_order0", 32'(order_at(0)), 32'd1);
    chk("gap_order1", 32'(order_at(1)), 32'd2);
    chk("gap_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Random traffic with valid holes and FIFO back-pressure.
    for (int t = 0; t < 600; t++) begin
      for (int s = 0; s < N; s++) begin
        if (stim_q[s].size() < 10 && $urandom_range(0, 7) == 0)
          add_pkt(s, int'($urandom_range(2, MAXLEN)));
        hold[s] = ($urandom_range(0, 3) == 0);
      end
      af_drv = ($urandom_range(0, 4) == 0);
      full_drv = ($urandom_range(0, 9) == 0);
      step();
    end
    for (int s = 0; s < N; s++) hold[s] = 1'b0;
    af_drv = 1'b0;
    full_drv = 1'b0;
    drain(2000);
    chk("rand_pkt_count", 32'(pkt_count), 32'(exp_pkts & 32'hFFFF));
    chk("rand_err_len", 32'(err_len), 32'd0);

    // Reset mid-packet.
    add_pkt(0, MAXLEN);
    add_pkt(3, 3);
    step();
    step();
    step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_ready", 32'(src_ready), 32'd0);
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("midrst_grant", 32'(grant_id), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
    clear_model();
    drive();
    @(negedge clk);
    rstn = 1'b1;
    add_pkt(2, 3);
    add_pkt(0, 3);
    drain(100);
    chk("midrst_first_src0", 32'(order_at(0)), 32'd0);
    chk("midrst_second_src2", 32'(order_at(1)), 32'd2);

`ifdef L2ARB_LEN_GUARD_EN
    // Length guard: 6 words without EOP, truncated after 3 with injected EOP.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      stim_q[0].push_back(mkword(0));
      if (k < 3) exp_q[0].push_back(stim_q[0][k]);
    end
    exp_q[0].push_back(EOP_WORD);
    exp_pkts = 1;
    add_pkt(1, 3);
    for (int i = 0; i < 40 && !err_len; i++) step();
    chk("guard_err_len", 32'(err_len), 32'd1);
    stim_q[0].delete();
    drain(100);
    chk("guard_order0", 32'(order_at(0)), 32'd0);
    chk("guard_order1", 32'(order_at(1)), 32'd1);
    chk("guard_pkt_count", 32'(pkt_count), 32'd2);
    chk("guard_err_sticky", 32'(err_len), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
